// File: rtl/alu_exec.sv
// ============================================================================
//  Module   : alu_exec
//  Purpose  : 8-bit execute stage with two-deep write-port forwarding and a
//             multi-cycle shift-add multiplier stalling the decoder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_exec #(
   parameter int WORD_W     = 8,
   parameter int ADDR_W     = 2,
   parameter int MUL_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [ADDR_W-1:0] dst,
   input  logic [WORD_W-1:0] rd_data1,
   input  logic [WORD_W-1:0] rd_data2,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              wr_en,
   output logic              flag_z,
   output logic              flag_c,
   output logic              busy
);

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_MUL  = 1'b1;

   localparam logic [2:0] c_OP_ADD = 3'd0;
   localparam logic [2:0] c_OP_SUB = 3'd1;
   localparam logic [2:0] c_OP_AND = 3'd2;
   localparam logic [2:0] c_OP_OR  = 3'd3;
   localparam logic [2:0] c_OP_XOR = 3'd4;
   localparam logic [2:0] c_OP_SHL = 3'd5;
   localparam logic [2:0] c_OP_MUL = 3'd6;
   localparam logic [2:0] c_OP_CMP = 3'd7;

   localparam int                 c_CNT_W    = $clog2(MUL_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MUL_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   logic [0:0]          r_state;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [WORD_W-1:0]   r_wr_data;
   logic                r_wr_en;
   logic                r_flag_z;
   logic                r_flag_c;
   logic [ADDR_W-1:0]   r_prev_addr;
   logic [WORD_W-1:0]   r_prev_data;
   logic                r_prev_en;
   logic [WORD_W-1:0]   r_ma;
   logic [WORD_W-1:0]   r_mb;
   logic [ADDR_W-1:0]   r_mdst;
   logic [2*WORD_W-1:0] r_acc;
   logic [c_CNT_W-1:0]  r_cnt;

   logic                w_accept;
   logic [WORD_W-1:0]   w_opa;
   logic [WORD_W-1:0]   w_opb;
   logic [WORD_W:0]     w_res;
   logic [2*WORD_W-1:0] w_addend;
   logic [2*WORD_W-1:0] w_acc_nxt;

   assign in_ready = (r_state == c_IDLE) && rst_n;
   assign busy     = (r_state == c_MUL);
   assign w_accept = in_valid && in_ready;

   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;
   assign wr_en   = r_wr_en;
   assign flag_z  = r_flag_z;
   assign flag_c  = r_flag_c;

   // Newest write wins: the committing write shadows the one from last cycle.
   always_comb begin
      w_opa = rd_data1;
      if (r_wr_en && (rs1 == r_wr_addr))
         w_opa = r_wr_data;
      else if (r_prev_en && (rs1 == r_prev_addr))
         w_opa = r_prev_data;

      w_opb = rd_data2;
      if (r_wr_en && (rs2 == r_wr_addr))
         w_opb = r_wr_data;
      else if (r_prev_en && (rs2 == r_prev_addr))
         w_opb = r_prev_data;
   end

   // Bit WORD_W of w_res is the carry (ADD), borrow (SUB/CMP) or shifted-out bit.
   always_comb begin
      w_res = '0;
      case (op)
         c_OP_ADD: w_res = {1'b0, w_opa} + {1'b0, w_opb};
         c_OP_SUB,
         c_OP_CMP: w_res = {1'b0, w_opa} - {1'b0, w_opb};
         c_OP_AND: w_res = {1'b0, w_opa & w_opb};
         c_OP_OR:  w_res = {1'b0, w_opa | w_opb};
         c_OP_XOR: w_res = {1'b0, w_opa ^ w_opb};
         c_OP_SHL: w_res = {w_opa, 1'b0};
         default:  w_res = '0;
      endcase
   end

   assign w_addend  = r_mb[0] ? ({{WORD_W{1'b0}}, r_ma} << r_cnt) : '0;
   assign w_acc_nxt = r_acc + w_addend;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= c_IDLE;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_flag_z    <= 1'b0;
         r_flag_c    <= 1'b0;
         r_prev_en   <= 1'b0;
         r_prev_addr <= '0;
         r_prev_data <= '0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_ma        <= '0;
         r_mb        <= '0;
         r_mdst      <= '0;
      end else begin
         r_prev_addr <= r_wr_addr;
         r_prev_data <= r_wr_data;
         r_prev_en   <= r_wr_en;
         r_wr_en     <= 1'b0;

         if (r_state == c_MUL) begin
            r_acc <= w_acc_nxt;
            r_mb  <= r_mb >> 1;
            r_cnt <= r_cnt + c_CNT_ONE;
            // The final iteration's sum goes straight to the write port.
            if (r_cnt == c_CNT_LAST) begin
               r_state   <= c_IDLE;
               r_wr_en   <= 1'b1;
               r_wr_addr <= r_mdst;
               r_wr_data <= w_acc_nxt[WORD_W-1:0];
               r_flag_z  <= (w_acc_nxt[WORD_W-1:0] == '0);
               r_flag_c  <= |w_acc_nxt[2*WORD_W-1:WORD_W];
            end
         end else if (w_accept) begin
            if (op == c_OP_MUL) begin
               r_ma    <= w_opa;
               r_mb    <= w_opb;
               r_mdst  <= dst;
               r_acc   <= '0;
               r_cnt   <= '0;
               r_state <= c_MUL;
            end else begin
               r_flag_z <= (w_res[WORD_W-1:0] == '0);
               r_flag_c <= w_res[WORD_W];
               if (op != c_OP_CMP) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= dst;
                  r_wr_data <= w_res[WORD_W-1:0];
               end
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
//  Module   : tb_alu_exec
//  Purpose  : Directed and random checks of alu_exec against an architectural
//             register model with distance-based operand staleness.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec;

   localparam int MULC = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] op = '0;
   logic [1:0] rs1 = '0, rs2 = '0, dst = '0;
   logic [7:0] rd_data1 = '0, rd_data2 = '0;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_en, flag_z, flag_c, busy;

   alu_exec #(.WORD_W(8), .ADDR_W(2), .MUL_CYCLES(MULC)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rs1(rs1), .rs2(rs2), .dst(dst),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: architectural registers, cycle of each register's last write,
   // the one outstanding result, current flags, first cycle the stage is free.
   int arch [4];
   int last_wr [4];
   int cyc = 0;
   int ready_cyc = 0;
   bit known = 0;
   bit ev_pend = 0, ev_we = 0, ev_z = 0, ev_c = 0;
   int ev_cyc = 0, ev_addr = 0, ev_data = 0;
   bit mf_z = 0, mf_c = 0;

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void alu_ref(input int o, input int a, input int b,
                                   output int data, output bit z, output bit c);
      int r;
      c = 0;
      case (o)
         0: begin r = a + b;  c = (r > 255); end
         1, 7: begin r = a - b; c = (a < b); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: begin r = a * 2;  c = (a >= 128); end
         default: begin r = a * b; c = (r > 255); end
      endcase
      data = r & 255;
      z = (data == 0);
   endfunction

   // A register written in this cycle or the previous one is not yet visible
   // through the registered read port.
   function automatic bit stale(input int r);
      return last_wr[r] >= cyc - 1;
   endfunction

   task automatic tick(input bit rn, input bit v, input int o, input int r1,
                       input int r2, input int d, input int d1, input int d2,
                       input bit rnd);
      int a, b, data;
      bit z, c, busy_e, acc;
      if (rnd) begin
         d1 = stale(r1) ? int'($urandom_range(255)) : arch[r1];
         d2 = stale(r2) ? int'($urandom_range(255)) : arch[r2];
      end
      rst_n = rn; in_valid = v; op = 3'(o);
      rs1 = 2'(r1); rs2 = 2'(r2); dst = 2'(d);
      rd_data1 = 8'(d1); rd_data2 = 8'(d2);
      #1;
      busy_e = (cyc < ready_cyc);
      if (known) begin
         check("in_ready", 32'(in_ready), int'(rn && !busy_e));
         check("busy", 32'(busy), int'(busy_e));
      end
      acc = known && rn && v && !busy_e;
      if (acc) begin
         a = stale(r1) ? arch[r1] : d1;
         b = stale(r2) ? arch[r2] : d2;
         alu_ref(o, a, b, data, z, c);
         ev_pend = 1; ev_we = (o != 7); ev_addr = d; ev_data = data;
         ev_z = z; ev_c = c;
         ev_cyc = cyc + ((o == 6) ? MULC + 1 : 1);
         ready_cyc = ev_cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (!rn) begin
         known = 1; ev_pend = 0; mf_z = 0; mf_c = 0; ready_cyc = cyc;
         for (int i = 0; i < 4; i++) last_wr[i] = -100;
         check("rst_wr_en", 32'(wr_en), 0);
         check("rst_wr_addr", 32'(wr_addr), 0);
         check("rst_wr_data", 32'(wr_data), 0);
         check("rst_flag_z", 32'(flag_z), 0);
         check("rst_flag_c", 32'(flag_c), 0);
      end else if (known) begin
         if (ev_pend && ev_cyc == cyc) begin
            check("wr_en", 32'(wr_en), int'(ev_we));
            if (ev_we) begin
               check("wr_addr", 32'(wr_addr), ev_addr);
               check("wr_data", 32'(wr_data), ev_data);
               arch[ev_addr] = ev_data;
               last_wr[ev_addr] = cyc;
            end
            mf_z = ev_z; mf_c = ev_c; ev_pend = 0;
         end else begin
            check("wr_en_idle", 32'(wr_en), 0);
         end
         check("flag_z", 32'(flag_z), int'(mf_z));
         check("flag_c", 32'(flag_c), int'(mf_c));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         arch[i] = int'($urandom_range(255));
         last_wr[i] = -100;
      end

      // Reset held three cycles with a valid instruction present.
      for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 1, 2, 8'h11, 8'h22, 0);
      tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // ADD 0xFF + 0x01 -> r2
      tick(1, 1, 0, 0, 1, 2, 8'hFF, 8'h01, 0);
      check("add_data", 32'(wr_data), 8'h00);
      check("add_addr", 32'(wr_addr), 2);
      check("add_z", 32'(flag_z), 1);
      check("add_c", 32'(flag_c), 1);
      // SUB 0x03 - 0x05 -> r3, then CMP 5,5
      tick(1, 1, 1, 0, 1, 3, 8'h03, 8'h05, 0);
      check("sub_data", 32'(wr_data), 8'hFE);
      check("sub_c", 32'(flag_c), 1);
      tick(1, 1, 7, 0, 1, 0, 8'h05, 8'h05, 0);
      check("cmp_no_wr", 32'(wr_en), 0);
      check("cmp_z", 32'(flag_z), 1);
      idle(3);

      // Distance-1 forwarding: r1 = 0x30, then r2 = r1 + r1 with stale reads.
      tick(1, 1, 0, 0, 3, 1, 8'h10, 8'h20, 0);
      tick(1, 1, 0, 1, 1, 2, 8'h00, 8'h00, 0);
      check("fwd1_data", 32'(wr_data), 8'h60);
      idle(3);
      // Distance-2 forwarding through the previous-write copy.
      tick(1, 1, 0, 0, 3, 1, 8'h10, 8'h20, 0);
      idle(1);
      tick(1, 1, 0, 1, 1, 2, 8'h00, 8'h00, 0);
      check("fwd2_data", 32'(wr_data), 8'h60);
      idle(3);

      // MUL 0x0F * 0x11 = 0x0FF
      tick(1, 1, 6, 0, 3, 1, 8'h0F, 8'h11, 0);
      idle(MULC);
      check("mul1_data", 32'(wr_data), 8'hFF);
      check("mul1_c", 32'(flag_c), 0);
      idle(3);
      // MUL 0x10 * 0x10 = 0x100
      tick(1, 1, 6, 0, 3, 2, 8'h10, 8'h10, 0);
      idle(MULC);
      check("mul2_data", 32'(wr_data), 8'h00);
      check("mul2_z", 32'(flag_z), 1);
      check("mul2_c", 32'(flag_c), 1);
      idle(3);

      // Stall: ADD r2 = r1 + 1 held during MUL r1 = 3*5; forwards the product.
      tick(1, 1, 6, 0, 3, 1, 8'h03, 8'h05, 0);
      for (int i = 0; i <= MULC; i++) tick(1, 1, 0, 1, 0, 2, 8'h00, 8'h01, 0);
      check("stall_data", 32'(wr_data), 8'h10);
      check("stall_addr", 32'(wr_addr), 2);
      idle(3);

      // Reset four cycles into a MUL aborts it.
      tick(1, 1, 6, 0, 3, 1, 8'h07, 8'h07, 0);
      idle(3);
      tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("abort_busy", 32'(busy), 0);
      idle(MULC);

      // Random instruction stream with hazard-dependent stale read data.
      for (int i = 0; i < 400; i++)
         tick($urandom_range(63) != 0, $urandom_range(3) != 0,
              int'($urandom_range(7)), int'($urandom_range(3)),
              int'($urandom_range(3)), int'($urandom_range(3)), 0, 0, 1);
      idle(MULC + 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
